// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings for the multiply/divide sequencer
// Purpose: operation codes, FSM state encodings and counter width used by
//          md_sequencer and md_arith.
// Ports:   none (package).
package md_pkg;

  localparam int MD_CNT_W = 4;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MADD  = 3'd4,
    MD_OP_MADDU = 3'd5,
    MD_OP_MSUB  = 3'd6,
    MD_OP_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - issue/mt/result bundle between E stage and sequencer
// Purpose: groups the E-stage issue strobe, operands, mthi/mtlo write port
//          and the busy/done/hi/lo results.
// Ports:   master = E stage side (drives start, md_op, rs_val, rt_val, req,
//          mt_hi, mt_lo, mt_data); slave = sequencer side (drives busy,
//          done, hi, lo).
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, req, mt_hi, mt_lo, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, req, mt_hi, mt_lo, mt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide/accumulate datapath
// Purpose: 64-bit product, quotient/remainder and (with MD_MADD_EN) the
//          madd/maddu/msub/msubu accumulate for the sequencer.
// Ports:   i_op     operation code
//          i_a/i_b  operands (dividend/multiplicand, divisor/multiplier)
//          i_acc    {hi,lo} accumulate base (only with MD_MADD_EN)
//          o_result {hi,lo} result
//          o_valid  operation code is defined in this build
//          o_write  result should update hi/lo (false for divide by zero)
//          o_is_div operation uses the divide latency
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MD_MADD_EN
  input  logic [63:0] i_acc,
`endif
  output logic [63:0] o_result,
  output logic        o_valid,
  output logic        o_write,
  output logic        o_is_div
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uden;
  logic [31:0] w_sden;
  logic [31:0] w_uq, w_ur, w_mq, w_mr, w_sq, w_sr;
  logic        w_b_nz;

  // Sign-extended operands multiplied modulo 2^64 give the signed product.
  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Signed division is done on magnitudes and re-signed afterwards, which
  // also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow traps.
  assign w_b_nz  = |i_b;
  assign w_abs_a = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_abs_b = i_b[31] ? (~i_b + 32'd1) : i_b;
  assign w_uden  = w_b_nz ? i_b : 32'd1;
  assign w_sden  = w_b_nz ? w_abs_b : 32'd1;
  assign w_uq    = i_a / w_uden;
  assign w_ur    = i_a % w_uden;
  assign w_mq    = w_abs_a / w_sden;
  assign w_mr    = w_abs_a % w_sden;
  assign w_sq    = (i_a[31] ^ i_b[31]) ? (~w_mq + 32'd1) : w_mq;
  assign w_sr    = i_a[31] ? (~w_mr + 32'd1) : w_mr;

  always_comb begin
    o_result = 64'd0;
    o_valid  = 1'b0;
    o_write  = 1'b0;
    o_is_div = 1'b0;
    case (md_op_e'(i_op))
      MD_OP_MULT:  begin o_valid = 1'b1; o_write = 1'b1; o_result = w_sprod; end
      MD_OP_MULTU: begin o_valid = 1'b1; o_write = 1'b1; o_result = w_uprod; end
      MD_OP_DIV: begin
        o_valid  = 1'b1;
        o_is_div = 1'b1;
        o_write  = w_b_nz;
        o_result = {w_sr, w_sq};
      end
      MD_OP_DIVU: begin
        o_valid  = 1'b1;
        o_is_div = 1'b1;
        o_write  = w_b_nz;
        o_result = {w_ur, w_uq};
      end
`ifdef MD_MADD_EN
      MD_OP_MADD:  begin o_valid = 1'b1; o_write = 1'b1; o_result = i_acc + w_sprod; end
      MD_OP_MADDU: begin o_valid = 1'b1; o_write = 1'b1; o_result = i_acc + w_uprod; end
      MD_OP_MSUB:  begin o_valid = 1'b1; o_write = 1'b1; o_result = i_acc - w_sprod; end
      MD_OP_MSUBU: begin o_valid = 1'b1; o_write = 1'b1; o_result = i_acc - w_uprod; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Purpose: accepts one mult/multu/div/divu issue, counts out a fixed latency
//          and then commits the result to HI/LO. Optional feature macro
//          MD_MADD_EN adds madd/maddu/msub/msubu accumulating into HI/LO.
// Ports:   clk    rising-edge clock
//          reset  asynchronous active-high reset
//          bus    md_sequencer_if.slave (start/md_op/rs_val/rt_val/req,
//                 mt_hi/mt_lo/mt_data in; busy/done/hi/lo out)
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  md_sequencer_if.slave bus
);

  localparam logic [MD_CNT_W-1:0] LP_MULT = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] LP_DIV  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           r_state;
  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [63:0]         r_pend;
  logic                r_pend_wr;

  logic [63:0]         w_result;
  logic                w_valid;
  logic                w_write;
  logic                w_is_div;
  logic [MD_CNT_W-1:0] w_lat;
  logic                w_issue;
  logic                w_mt_ok;

  md_arith u_arith (
    .i_op     (bus.md_op),
    .i_a      (bus.rs_val),
    .i_b      (bus.rt_val),
`ifdef MD_MADD_EN
    .i_acc    ({r_hi, r_lo}),
`endif
    .o_result (w_result),
    .o_valid  (w_valid),
    .o_write  (w_write),
    .o_is_div (w_is_div)
  );

  assign w_lat   = w_is_div ? LP_DIV : LP_MULT;
  assign w_issue = bus.start & ~bus.req & (r_state == IDLE) & w_valid;
  assign w_mt_ok = (r_state == IDLE) & ~bus.req & ~bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend    <= 64'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state   <= RUN;
            r_cnt     <= w_lat;
            r_busy    <= 1'b1;
            r_done    <= (w_lat == MD_CNT_W'(1));
            r_pend    <= w_result;
            r_pend_wr <= w_write;
          end else if (w_mt_ok) begin
            if (bus.mt_hi) r_hi <= bus.mt_data;
            if (bus.mt_lo) r_lo <= bus.mt_data;
          end
        end
        RUN: begin
          // cnt==1 marks the last busy cycle; the result lands on its edge.
          if (r_cnt == MD_CNT_W'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            if (r_pend_wr) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
          end else begin
            r_cnt  <= r_cnt - MD_CNT_W'(1);
            r_done <= (r_cnt == MD_CNT_W'(2));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.start && r_state == RUN))
        else $error("md_sequencer: start issued while an operation is running");
      assert (!(bus.start && (bus.mt_hi || bus.mt_lo)))
        else $error("md_sequencer: mthi/mtlo in the same cycle as start");
    end
  end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed self-checking bench for md_sequencer
module tb_md_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   nb, nd, dpos;

  md_sequencer_if bus();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.req    = rq;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.req    = 1'b0;
  endtask

  task automatic do_mt(input logic h, input logic l, input logic [31:0] d, input logic rq);
    @(negedge clk);
    bus.mt_hi   = h;
    bus.mt_lo   = l;
    bus.mt_data = d;
    bus.req     = rq;
    @(negedge clk);
    bus.mt_hi   = 1'b0;
    bus.mt_lo   = 1'b0;
    bus.req     = 1'b0;
  endtask

  // Samples at negedges from the current one; stops once busy has fallen.
  task automatic run_count(input int budget, output int o_nb, output int o_nd, output int o_dpos);
    o_nb = 0; o_nd = 0; o_dpos = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.busy) o_nb++;
      if (bus.done) begin o_nd++; o_dpos = o_nb; end
      if (!bus.busy && o_nb > 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 0; bus.md_op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.req = 0; bus.mt_hi = 0; bus.mt_lo = 0; bus.mt_data = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    reset = 1'b0;

    // mult -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_count(30, nb, nd, dpos);
    check("mult_busy_cycles", nb, 5);
    check("mult_done_count", nd, 1);
    check("mult_done_pos", dpos, 5);
    check("mult_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, bus.lo}, 64'hFFFF_FFF1);

    // divu 7/2
    issue(3'd3, 32'd7, 32'd2, 1'b0);
    run_count(30, nb, nd, dpos);
    check("divu_busy_cycles", nb, 10);
    check("divu_done_pos", dpos, 10);
    check("divu_hi", {32'd0, bus.hi}, 64'd1);
    check("divu_lo", {32'd0, bus.lo}, 64'd3);

    // div -7/2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_count(30, nb, nd, dpos);
    check("div_neg_busy", nb, 10);
    check("div_neg_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("div_neg_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);

    // start squashed by req
    issue(3'd2, 32'd9, 32'd3, 1'b1);
    run_count(14, nb, nd, dpos);
    check("req_squash_busy", nb, 0);
    check("req_squash_done", nd, 0);
    check("req_squash_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("req_squash_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);

    // mthi/mtlo then divide by zero
    do_mt(1'b1, 1'b0, 32'h11, 1'b0);
    do_mt(1'b0, 1'b1, 32'h22, 1'b0);
    check("mt_hi", {32'd0, bus.hi}, 64'h11);
    check("mt_lo", {32'd0, bus.lo}, 64'h22);
    do_mt(1'b1, 1'b1, 32'h99, 1'b1);
    check("mt_req_hi", {32'd0, bus.hi}, 64'h11);
    check("mt_req_lo", {32'd0, bus.lo}, 64'h22);
    issue(3'd2, 32'd5, 32'd0, 1'b0);
    run_count(30, nb, nd, dpos);
    check("div0_busy", nb, 10);
    check("div0_done", nd, 1);
    check("div0_hi", {32'd0, bus.hi}, 64'h11);
    check("div0_lo", {32'd0, bus.lo}, 64'h22);

    // overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_count(30, nb, nd, dpos);
    check("div_ovf_hi", {32'd0, bus.hi}, 64'd0);
    check("div_ovf_lo", {32'd0, bus.lo}, 64'h8000_0000);

    // div 7 / -2
    issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_count(30, nb, nd, dpos);
    check("div_negb_hi", {32'd0, bus.hi}, 64'd1);
    check("div_negb_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);

    // multu max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_count(30, nb, nd, dpos);
    check("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);

    // mthi during RUN is ignored
    issue(3'd0, 32'd2, 32'd3, 1'b0);
    do_mt(1'b1, 1'b0, 32'hDEAD, 1'b0);
    run_count(30, nb, nd, dpos);
    check("mt_in_run_busy", nb, 3);
    check("mt_in_run_hi", {32'd0, bus.hi}, 64'd0);
    check("mt_in_run_lo", {32'd0, bus.lo}, 64'd6);

    // req during RUN does not cancel
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk); bus.req = 1'b1;
    @(negedge clk); bus.req = 1'b0;
    run_count(30, nb, nd, dpos);
    check("req_in_run_busy", nb, 8);
    check("req_in_run_hi", {32'd0, bus.hi}, 64'd2);
    check("req_in_run_lo", {32'd0, bus.lo}, 64'd14);

    // maddu 1*1 onto hi=0, lo=0xFFFFFFFF
    do_mt(1'b1, 1'b1, 32'd0, 1'b0);
    do_mt(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue(3'd5, 32'd1, 32'd1, 1'b0);
    run_count(14, nb, nd, dpos);
`ifdef MD_MADD_EN
    check("maddu_busy", nb, 5);
    check("maddu_hi", {32'd0, bus.hi}, 64'd1);
    check("maddu_lo", {32'd0, bus.lo}, 64'd0);
`else
    check("maddu_undef_busy", nb, 0);
    check("maddu_undef_hi", {32'd0, bus.hi}, 64'd0);
    check("maddu_undef_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
`endif

    // reset in 3rd busy cycle of multu
    do_mt(1'b1, 1'b1, 32'h55, 1'b0);
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_hi", {32'd0, bus.hi}, 64'd0);
    check("mid_rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_count(10, nb, nd, dpos);
    check("post_rst_busy", nb, 0);
    check("post_rst_hi", {32'd0, bus.hi}, 64'd0);
    check("post_rst_lo", {32'd0, bus.lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
